// File: rtl/multicycle_adder_sub_if.sv
// Operand/result handshake bundle for the multi-cycle adder/subtractor.
// The slave side is the arithmetic block, the master side is the operand source and result consumer.
interface multicycle_adder_sub_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             busy;

  modport slave (
    input  in_valid, op_a, op_b, mode, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow, busy
  );

  modport master (
    output in_valid, op_a, op_b, mode, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow, busy
  );
endinterface

// File: rtl/multicycle_adder_sub.sv
// Digit-serial adder/subtractor with accumulator: one DIGIT-wide slice per clock,
// valid/ready on both sides, carry-out and signed overflow reported with the result.
module multicycle_adder_sub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_adder_sub_if.slave bus
);
  localparam int NSLICE = WIDTH / DIGIT;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] M_SUB = 2'b01;
  localparam logic [1:0] M_ACC = 2'b10;
  localparam logic [1:0] M_CLR = 2'b11;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q, acc, sum_q;
  logic             carry_q, is_acc;
  logic [CW-1:0]    cnt;
  logic             in_ready_q, out_valid_q, busy_q, cout_q, ovf_q;

  logic [DIGIT-1:0] a_sl, b_sl;
  logic [DIGIT:0]   sl_sum;
  logic [WIDTH-1:0] sum_nxt;
  logic             msb_cin, last;

  always_comb begin
    a_sl    = a_q[cnt*DIGIT +: DIGIT];
    b_sl    = b_q[cnt*DIGIT +: DIGIT];
    sl_sum  = {1'b0, a_sl} + {1'b0, b_sl} + carry_q;
    sum_nxt = sum_q;
    sum_nxt[cnt*DIGIT +: DIGIT] = sl_sum[DIGIT-1:0];
    // carry into the MSB recovered from the MSB's own sum bit, independent of DIGIT
    msb_cin = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum_nxt[WIDTH-1];
    last    = (cnt == CW'(NSLICE - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      is_acc      <= 1'b0;
      cnt         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            if (bus.mode == M_CLR) begin
              acc <= '0;
            end else begin
              a_q        <= bus.op_a;
              b_q        <= (bus.mode == M_SUB) ? ~bus.op_b :
                            (bus.mode == M_ACC) ? acc : bus.op_b;
              carry_q    <= (bus.mode == M_SUB);
              is_acc     <= (bus.mode == M_ACC);
              cnt        <= '0;
              state      <= CALC;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end
          end
        end
        CALC: begin
          sum_q   <= sum_nxt;
          carry_q <= sl_sum[DIGIT];
          if (last) begin
            cout_q      <= sl_sum[DIGIT];
            ovf_q       <= msb_cin ^ sl_sum[DIGIT];
            out_valid_q <= 1'b1;
            state       <= DONE;
            if (is_acc) acc <= sum_nxt;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.busy      = busy_q;
endmodule
